// File: rtl/edge_generator_pkg.sv
// Shared types and helpers for the edge generator and its hold counter.
package edge_gen_pkg;

    localparam int unsigned DEF_MIN_HIGH = 4;
    localparam int unsigned DEF_MIN_LOW  = 4;
    localparam int unsigned DEF_CNT_W    = 8;

    // Line level plus whether the minimum hold time is still running.
    typedef enum logic [1:0] {
        LOW_IDLE  = 2'b00,
        LOW_HOLD  = 2'b01,
        HIGH_IDLE = 2'b10,
        HIGH_HOLD = 2'b11
    } edge_gen_state_t;

    // Counter load for the level the line is moving to. The counter reaches
    // zero in the last cycle the level must be held, hence the minus one.
    function automatic int unsigned hold_load(
        input logic        level,
        input int unsigned min_high,
        input int unsigned min_low
    );
        return level ? (min_high - 1) : (min_low - 1);
    endfunction

endpackage

// File: rtl/edge_generator_hold_counter.sv
// Down-counter timing the minimum hold of the current line level.
module hold_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load on every edge, otherwise count down to zero and stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/edge_generator.sv
// Edge generator: turns single-cycle rise/fall requests into edges on a
// registered line while enforcing minimum high and low hold times.
//
// state     | meaning
// LOW_IDLE  | line low, hold satisfied (also the state after reset)
// LOW_HOLD  | line low, minimum low time still counting
// HIGH_IDLE | line high, hold satisfied
// HIGH_HOLD | line high, minimum high time still counting
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
    parameter int unsigned MIN_LOW  = DEF_MIN_LOW,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rise_req,
    input  logic i_fall_req,
    output logic o_data_out,
    output logic o_rise_done,
    output logic o_fall_done,
    output logic o_req_dropped,
    output logic o_busy
);

    edge_gen_state_t r_state;
    edge_gen_state_t w_state_nxt;

    logic r_pend;
    logic r_data_out;
    logic r_rise_done;
    logic r_fall_done;
    logic r_dropped;

    logic w_pend_nxt;
    logic w_go;
    logic w_drop;
    logic w_high;
    logic w_hold;
    logic w_hold_done;
    logic w_cnt_zero;
    logic [CNT_W-1:0] w_load_val;

    assign w_high      = (r_state == HIGH_IDLE) || (r_state == HIGH_HOLD);
    assign w_hold      = (r_state == LOW_HOLD)  || (r_state == HIGH_HOLD);
    assign w_hold_done = !w_hold || w_cnt_zero;

    // The new level is the opposite of the current one.
    assign w_load_val = CNT_W'(hold_load(!w_high, MIN_HIGH, MIN_LOW));

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_go),
        .i_load_val (w_load_val),
        .i_dec      (w_hold),
        .o_zero     (w_cnt_zero)
    );

    // Request arbitration and next-state selection. A pending edge always
    // fires once the hold completes, even if a new request is dropped in the
    // same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_go        = 1'b0;
        w_drop      = 1'b0;

        if (r_pend) begin
            w_drop = i_rise_req || i_fall_req;
            if (w_hold_done) begin
                w_go       = 1'b1;
                w_pend_nxt = 1'b0;
            end
        end else if (i_rise_req && i_fall_req) begin
            w_drop = 1'b1;
        end else if (i_rise_req) begin
            if (w_high) begin
                w_drop = 1'b1;
            end else if (w_hold_done) begin
                w_go = 1'b1;
            end else begin
                w_pend_nxt = 1'b1;
            end
        end else if (i_fall_req) begin
            if (!w_high) begin
                w_drop = 1'b1;
            end else if (w_hold_done) begin
                w_go = 1'b1;
            end else begin
                w_pend_nxt = 1'b1;
            end
        end

        if (w_go) begin
            w_state_nxt = w_high ? LOW_HOLD : HIGH_HOLD;
        end else if (w_hold && w_cnt_zero) begin
            w_state_nxt = w_high ? HIGH_IDLE : LOW_IDLE;
        end
    end

    // State, pending flag and registered outputs; reset drops any pending edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOW_IDLE;
            r_pend      <= 1'b0;
            r_data_out  <= 1'b0;
            r_rise_done <= 1'b0;
            r_fall_done <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_data_out  <= w_go ? !w_high : w_high;
            r_rise_done <= w_go && !w_high;
            r_fall_done <= w_go && w_high;
            r_dropped   <= w_drop;
        end
    end

    assign o_data_out    = r_data_out;
    assign o_rise_done   = r_rise_done;
    assign o_fall_done   = r_fall_done;
    assign o_req_dropped = r_dropped;
    assign o_busy        = w_hold || r_pend;

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: directed tables, a reset-in-hold sequence and a
// randomized pass checked by a reference model and an edge detector.
module tb_edge_generator;

    localparam int A_HIGH = 4;
    localparam int A_LOW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_rise = 1'b0, a_fall = 1'b0;
    logic b_rise = 1'b0, b_fall = 1'b0;
    logic a_data, a_rd, a_fd, a_drop, a_busy;
    logic b_data, b_rd, b_fd, b_drop, b_busy;

    always #5 clk = ~clk;

    edge_generator #(.MIN_HIGH(A_HIGH), .MIN_LOW(A_LOW), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .i_rise_req(a_rise), .i_fall_req(a_fall),
        .o_data_out(a_data), .o_rise_done(a_rd), .o_fall_done(a_fd),
        .o_req_dropped(a_drop), .o_busy(a_busy)
    );

    edge_generator #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .i_rise_req(b_rise), .i_fall_req(b_fall),
        .o_data_out(b_data), .o_rise_done(b_rd), .o_fall_done(b_fd),
        .o_req_dropped(b_drop), .o_busy(b_busy)
    );

    // {data_out, rise_done, fall_done, req_dropped, busy}
    typedef struct {
        logic       r;
        logic       f;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [4:0] outs_a();
        return {a_data, a_rd, a_fd, a_drop, a_busy};
    endfunction

    function automatic logic [4:0] outs_b();
        return {b_data, b_rd, b_fd, b_drop, b_busy};
    endfunction

    task automatic check5(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (data,rise_done,fall_done,dropped,busy) t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_min(input string name, input int got, input int min);
        n_vec++;
        if (got < min) begin
            n_err++;
            $display("FAIL %s: got %0d expected at least %0d t=%0t", name, got, min, $time);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic [4:0] exp);
        vec_t v;
        v.r = r; v.f = f; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Called at a negedge: drive, push expectation, sample at the next negedge.
    task automatic step(input bit sel, input logic r, input logic f,
                        input logic [4:0] exp, input string name);
        logic [4:0] e;
        if (sel) begin b_rise = r; b_fall = f; end
        else     begin a_rise = r; a_fall = f; end
        sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        a_rise = 1'b0; a_fall = 1'b0; b_rise = 1'b0; b_fall = 1'b0;
        e = sb_q.pop_front();
        check5(name, sel ? outs_b() : outs_a(), e);
    endtask

    task automatic run_table(input bit sel, input string name);
        foreach (tbl[i]) step(sel, tbl[i].r, tbl[i].f, tbl[i].exp, $sformatf("%s[%0d]", name, i));
        tbl.delete();
    endtask

    // Reference model for DUT A: level, cycles spent at that level, pending flag.
    logic m_lvl;
    int   m_age;
    logic m_pend;
    int   m_nrise, m_nfall;

    task automatic model_reset();
        m_lvl = 1'b0; m_age = 1000; m_pend = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic f, output logic [4:0] exp);
        logic complete, go, drop;
        int   min_now;
        complete = (m_age >= (m_lvl ? A_HIGH : A_LOW));
        go = 1'b0; drop = 1'b0;
        if (m_pend) begin
            drop = r | f;
            if (complete) begin go = 1'b1; m_pend = 1'b0; end
        end else if (r && f) begin
            drop = 1'b1;
        end else if (r) begin
            if (m_lvl) drop = 1'b1;
            else if (complete) go = 1'b1;
            else m_pend = 1'b1;
        end else if (f) begin
            if (!m_lvl) drop = 1'b1;
            else if (complete) go = 1'b1;
            else m_pend = 1'b1;
        end
        if (go) begin
            m_lvl = !m_lvl;
            m_age = 1;
            if (m_lvl) m_nrise++; else m_nfall++;
        end else if (m_age < 1000) begin
            m_age++;
        end
        min_now = m_lvl ? A_HIGH : A_LOW;
        exp = {m_lvl, go & m_lvl, go & !m_lvl, drop, m_pend || (m_age <= min_now)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion within budget");
        $fatal(1);
    end

    initial begin
        logic [4:0] e;
        logic [4:0] got;
        logic       prev;
        int         width, n_pos, n_neg;
        bit         seg_valid;
        logic       r, f;
        int unsigned sel;

        // Reset state
        repeat (2) @(negedge clk);
        check5("reset_a", outs_a(), 5'b00000);
        check5("reset_b", outs_b(), 5'b00000);
        rst = 1'b0;

        // Rise two cycles after reset release, full hold, then fall and low hold
        add(0,0,5'b00000); add(0,0,5'b00000); add(1,0,5'b11001);
        add(0,0,5'b10001); add(0,0,5'b10001); add(0,0,5'b10001);
        add(0,0,5'b10000); add(0,1,5'b00101); add(0,0,5'b00001);
        add(0,0,5'b00001); add(0,0,5'b00000);
        run_table(0, "rise_fall_basic");

        // Fall requested one cycle after the rise is pended until the high hold ends
        add(1,0,5'b11001); add(0,1,5'b10001); add(0,0,5'b10001);
        add(0,0,5'b10001); add(0,0,5'b00101); add(0,0,5'b00001);
        add(0,0,5'b00001); add(0,0,5'b00000);
        run_table(0, "pended_fall");

        // Drops: simultaneous, same-level high, second while pending, same-level low
        add(1,1,5'b00010); add(1,0,5'b11001); add(1,0,5'b10011);
        add(0,1,5'b10001); add(0,1,5'b10011); add(0,0,5'b00101);
        add(0,1,5'b00011); add(0,0,5'b00001); add(0,0,5'b00000);
        add(0,1,5'b00010);
        run_table(0, "drops");

        // MIN_HIGH = MIN_LOW = 1: toggle every cycle with no drops
        add(1,0,5'b11001); add(0,1,5'b00101); add(1,0,5'b11001);
        add(0,1,5'b00101); add(1,0,5'b11001); add(0,1,5'b00101);
        add(0,0,5'b00000);
        run_table(1, "toggle_min1");

        // Reset two cycles into the high hold with a fall pending
        step(0, 1, 0, 5'b11001, "rst_setup_rise");
        step(0, 0, 1, 5'b10001, "rst_setup_pend");
        #2 rst = 1'b1;
        #1 check5("rst_async_clear", outs_a(), 5'b00000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 5'b00000, "rst_no_fall_done");
        step(0, 1, 0, 5'b11001, "rst_then_rise");

        // Randomized pass from a fresh reset, checked against the model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        m_nrise = 0; m_nfall = 0;
        n_pos = 0; n_neg = 0;
        prev = 1'b0; width = 0; seg_valid = 1'b0;
        for (int i = 0; i < 412; i++) begin
            r = 1'b0; f = 1'b0;
            if (i < 400) begin
                sel = $urandom_range(0, 9);
                r = (sel == 0) || (sel == 1) || (sel == 4);
                f = (sel == 2) || (sel == 3) || (sel == 4);
            end
            model_step(r, f, e);
            sb_q.push_back(e);
            a_rise = r; a_fall = f;
            @(posedge clk);
            @(negedge clk);
            a_rise = 1'b0; a_fall = 1'b0;
            got = outs_a();
            check5("rand", got, sb_q.pop_front());
            if (a_data !== prev) begin
                if (seg_valid) begin
                    if (prev) check_min("rand_high_width", width, A_HIGH);
                    else      check_min("rand_low_width", width, A_LOW);
                end
                if (a_data) n_pos++; else n_neg++;
                seg_valid = 1'b1;
                width = 1;
                prev = a_data;
            end else begin
                width++;
            end
        end
        check_int("rand_posedge_count", n_pos, m_nrise);
        check_int("rand_negedge_count", n_neg, m_nfall);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_generator.md
# edge_generator

Drives a single-bit output line with rising and falling edges on request, enforcing minimum high and low hold times on the line. It is the transmit-side counterpart of the edge detector: a downstream edge detector sampling `data_out` sees exactly one edge per accepted request. It sits between control logic issuing edge requests and any line that feeds an edge-sensitive consumer.

## Interface
- `MIN_HIGH`, default 4: minimum cycles `data_out` stays 1 after a rising edge; range 1..2^CNT_W.
- `MIN_LOW`, default 4: minimum cycles `data_out` stays 0 after a falling edge; range 1..2^CNT_W.
- `CNT_W`, default 8: hold-counter width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rise_req`  in  1  single-cycle request for a 0→1 edge.
- `fall_req`  in  1  single-cycle request for a 1→0 edge.
- `data_out`  out  1  generated line, registered.
- `rise_done`  out  1  one-cycle pulse, high in the first cycle `data_out`=1.
- `fall_done`  out  1  one-cycle pulse, high in the first cycle `data_out`=0 after a fall.
- `req_dropped`  out  1  one-cycle pulse, cycle after a rejected request.
- `busy`  out  1  high while in a HOLD state or while a request is pending.

## Operation
- Four FSM states: LOW_IDLE, LOW_HOLD, HIGH_IDLE, HIGH_HOLD. Reset state is LOW_IDLE.
- All outputs reset to 0. After reset the line counts as settled, so no hold time applies.
- Hold counter `cnt`, CNT_W bits:
  - Loaded with MIN_HIGH-1 on a rising edge and MIN_LOW-1 on a falling edge.
  - Decrements each cycle in a HOLD state.
  - Hold is complete when `cnt`==0, or in any IDLE state.
- Request arriving at a hold-complete cycle: the edge occurs on the next clock.
- Opposite-level request arriving during HOLD with `cnt`>0: stored in a one-deep pending flag. The edge occurs on the clock after the cycle where `cnt`==0.
- HOLD with `cnt`==0 and nothing pending: the next state is the matching IDLE.
- The following requests are dropped, with `req_dropped` pulsing the next cycle:
  - a same-level request (`rise_req` while the line is high or rising is pending, or `fall_req` while low);
  - any request while a pending flag is already set;
  - simultaneous `rise_req` and `fall_req`. Both are dropped, with one pulse.
- `rise_done` and `fall_done` are registered alongside `data_out` and coincide with its transition cycle.

## Timing
- Latency from a request in an IDLE state to the edge: 1 cycle.
- With back-to-back pending requests, `data_out` holds each level for exactly MIN_HIGH or MIN_LOW cycles.
- With MIN_x=1, the line may toggle every cycle.
- Asserting `rst` mid-hold or with a request pending:
  - `data_out` clears immediately;
  - the pending flag is cleared and the request is lost;
  - no done or dropped pulse is issued;
  - the block returns to LOW_IDLE.
- `busy` is combinational from the state register and the pending flag, and has no input-to-output path.

## Structure
- Package `edge_gen_pkg`:
  - state enum `edge_gen_state_t` (4 values);
  - function `hold_load(level)` returning MIN-1 for the counter load.
- Sub-module `hold_counter`, one natural choice:
  - load, decrement and zero-flag logic;
  - parameterised on CNT_W.
- The FSM, pending flag and output registers live in the top module.

## Test plan
- Reset release, then `rise_req` at cycle 2:
  - `data_out`=1 and `rise_done`=1 at cycle 3;
  - `busy` is high for cycles 3..6 with MIN_HIGH=4.
- `rise_req` at cycle 0 and `fall_req` at cycle 1, MIN_HIGH=4:
  - the fall is pended;
  - `data_out` is high for cycles 1..4 and falls at cycle 5;
  - `fall_done` pulses at cycle 5.
- `rise_req` while the line is high, a second `fall_req` while a fall is pending, and simultaneous `rise_req`+`fall_req` in LOW_IDLE:
  - each produces a single `req_dropped` pulse;
  - `data_out` is unchanged.
- MIN_HIGH=MIN_LOW=1 with alternating requests every cycle:
  - `data_out` toggles every cycle;
  - there are no drops.
- `rst` asserted two cycles into HIGH_HOLD with a fall pending:
  - `data_out` is 0 immediately;
  - no `fall_done` pulse;
  - after release, `rise_req` produces an edge one cycle later.
- A self-check pass feeds `data_out` into an edge-detector model under randomized requests:
  - the detected posedge and negedge counts equal the accepted request counts;
  - the measured high and low widths are never below MIN_HIGH/MIN_LOW.
